// File: rtl/bp_me_cfg_cmd_arbiter_if.sv
// Command/response bundle between the config command arbiter, its requesters and the IO network.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface bp_me_cfg_cmd_arbiter_if #(
    parameter int num_req_p   = 2,
    parameter int msg_width_p = 128
);
    logic [num_req_p*msg_width_p-1:0] req_cmd_i;
    logic [num_req_p-1:0]             req_cmd_v_i;
    logic [num_req_p-1:0]             req_cmd_yumi_o;
    logic [msg_width_p-1:0]           io_cmd_o;
    logic                             io_cmd_v_o;
    logic                             io_cmd_yumi_i;
    logic [msg_width_p-1:0]           io_resp_i;
    logic                             io_resp_v_i;
    logic                             io_resp_ready_o;
    logic [msg_width_p-1:0]           req_resp_o;
    logic [num_req_p-1:0]             req_resp_v_o;
    logic [num_req_p-1:0]             req_resp_ready_i;

    modport master (
        input  req_cmd_i, req_cmd_v_i, io_cmd_yumi_i, io_resp_i, io_resp_v_i, req_resp_ready_i,
        output req_cmd_yumi_o, io_cmd_o, io_cmd_v_o, io_resp_ready_o, req_resp_o, req_resp_v_o
    );

    modport slave (
        output req_cmd_i, req_cmd_v_i, io_cmd_yumi_i, io_resp_i, io_resp_v_i, req_resp_ready_i,
        input  req_cmd_yumi_o, io_cmd_o, io_cmd_v_o, io_resp_ready_o, req_resp_o, req_resp_v_o
    );
endinterface

// File: rtl/bp_me_cfg_cmd_arbiter.sv
// Round-robin arbiter funnelling requester commands onto one credited IO channel and
// routing in-order responses back to the issuing requester through an ID FIFO.
module bp_me_cfg_cmd_arbiter #(
    parameter int num_req_p     = 2,
    parameter int msg_width_p   = 128,
    parameter int max_credits_p = 8
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           drain_i,
    output logic                           idle_o,
    output logic                           err_o,
    bp_me_cfg_cmd_arbiter_if.master        bus
);
    localparam int id_w   = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int ptr_w  = $clog2(max_credits_p);
    localparam int cred_w = $clog2(max_credits_p + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e                 state_r, state_nxt_s;
    logic [id_w-1:0]        grant_r, grant_nxt_s, last_grant_r;
    logic [cred_w-1:0]      credits_r;
    logic [ptr_w-1:0]       wr_ptr_r, rd_ptr_r;
    logic [id_w-1:0]        id_mem_r [max_credits_p];
    logic                   err_r;
    logic [msg_width_p-1:0] cmd_slice_s [num_req_p];
    logic [id_w-1:0]        rr_idx_s, rr_winner_s, head_id_s;
    logic                   rr_found_s, cmd_fire_s, cred_full_s, cred_empty_s;
    logic                   resp_ready_s, push_s, pop_s;

    for (genvar g = 0; g < num_req_p; g++) begin : g_slice
        assign cmd_slice_s[g] = bus.req_cmd_i[g*msg_width_p +: msg_width_p];
    end

    assign cmd_fire_s   = (state_r == ST_SEND) & bus.io_cmd_yumi_i;
    assign cred_full_s  = (credits_r == cred_w'(max_credits_p));
    assign cred_empty_s = (credits_r == {cred_w{1'b0}});
    assign head_id_s    = id_mem_r[rd_ptr_r];
    assign push_s       = cmd_fire_s;
    // The ID FIFO occupancy always equals the credit count, so empty is credits==0.
    assign pop_s        = bus.io_resp_v_i & resp_ready_s & ~cred_empty_s;

    assign bus.io_cmd_v_o      = (state_r == ST_SEND);
    assign bus.io_cmd_o        = cmd_slice_s[grant_r];
    assign bus.req_resp_o      = bus.io_resp_i;
    assign bus.io_resp_ready_o = resp_ready_s;
    assign idle_o              = (state_r != ST_SEND) & cred_empty_s;
    assign err_o               = err_r;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        rr_found_s  = 1'b0;
        rr_winner_s = {id_w{1'b0}};
        rr_idx_s    = {id_w{1'b0}};
        for (int i = 1; i <= num_req_p; i++) begin
            rr_idx_s = id_w'((int'(last_grant_r) + i) % num_req_p);
            if (!rr_found_s && bus.req_cmd_v_i[rr_idx_s]) begin
                rr_found_s  = 1'b1;
                rr_winner_s = rr_idx_s;
            end else begin
                rr_found_s  = rr_found_s;
            end
        end
    end

    // Next-state and grant selection.
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_r;
        case (state_r)
            ST_IDLE: begin
                if (drain_i) begin
                    state_nxt_s = ST_DRAIN;
                end else if (!cred_full_s && rr_found_s) begin
                    state_nxt_s = ST_SEND;
                    grant_nxt_s = rr_winner_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (cmd_fire_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            ST_DRAIN: begin
                if (!drain_i && cred_empty_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Command consume strobe and response steering to the FIFO head.
    always_comb begin
        bus.req_cmd_yumi_o = {num_req_p{1'b0}};
        bus.req_resp_v_o   = {num_req_p{1'b0}};
        resp_ready_s       = 1'b1;
        if (cmd_fire_s) begin
            bus.req_cmd_yumi_o[grant_r] = 1'b1;
        end else begin
            bus.req_cmd_yumi_o = {num_req_p{1'b0}};
        end
        if (!cred_empty_s) begin
            bus.req_resp_v_o[head_id_s] = bus.io_resp_v_i;
            resp_ready_s                = bus.req_resp_ready_i[head_id_s];
        end else begin
            resp_ready_s                = 1'b1;
        end
    end

    // Control state: FSM, grant history, credits, FIFO pointers and sticky error.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r      <= ST_IDLE;
            grant_r      <= {id_w{1'b0}};
            last_grant_r <= id_w'(num_req_p - 1);
            credits_r    <= {cred_w{1'b0}};
            wr_ptr_r     <= {ptr_w{1'b0}};
            rd_ptr_r     <= {ptr_w{1'b0}};
            err_r        <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            grant_r <= grant_nxt_s;
            if (cmd_fire_s) begin
                last_grant_r <= grant_r;
            end
            case ({push_s, pop_s})
                2'b10:   credits_r <= credits_r + cred_w'(1);
                2'b01:   credits_r <= credits_r - cred_w'(1);
                default: credits_r <= credits_r;
            endcase
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ptr_w'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ptr_w'(1);
            end
            err_r <= err_r | (bus.io_resp_v_i & cred_empty_s);
        end
    end

    // ID storage carries no reset; validity is tracked by the pointers and credit count.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            id_mem_r[wr_ptr_r] <= grant_r;
        end
    end
endmodule

// File: tb/tb_bp_me_cfg_cmd_arbiter.sv
// Self-checking bench: table-driven grant sequence plus hand-written credit, drain,
// error and reset sequences; response routing is checked against a scoreboard of issued IDs.
module tb_bp_me_cfg_cmd_arbiter;
    localparam int NR = 2;
    localparam int MW = 32;
    localparam int MC = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic drain;
    logic idle;
    logic err;
    int   total = 0;
    int   bad   = 0;
    int   sb_q[$];
    logic [MW-1:0] cmd_data [NR];

    typedef struct {
        logic [1:0] v;
        int         exp_id;
    } cmd_vec_t;
    cmd_vec_t tbl [7];

    bp_me_cfg_cmd_arbiter_if #(.num_req_p(NR), .msg_width_p(MW)) bus ();

    bp_me_cfg_cmd_arbiter #(.num_req_p(NR), .msg_width_p(MW), .max_credits_p(MC)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .drain_i (drain),
        .idle_o  (idle),
        .err_o   (err),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] oh(input int id);
        logic [1:0] r;
        r = 2'b00;
        r[id[0]] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_cmd_v();
        for (int c = 0; c < 12; c++) begin
            if (bus.io_cmd_v_o === 1'b1) break;
            @(posedge clk); #1;
        end
        chk("cmd_v_timeout", 64'(bus.io_cmd_v_o), 64'd1);
    endtask

    task automatic issue(input logic [1:0] vmask, input int exp_id);
        cmd_data[0] = $urandom;
        cmd_data[1] = $urandom;
        bus.req_cmd_i   = {cmd_data[1], cmd_data[0]};
        bus.req_cmd_v_i = vmask;
        wait_cmd_v();
        chk("cmd_data", 64'(bus.io_cmd_o), 64'(cmd_data[exp_id[0]]));
        chk("yumi_early", 64'(bus.req_cmd_yumi_o), 64'd0);
        bus.io_cmd_yumi_i = 1'b1;
        #1;
        chk("cmd_yumi", 64'(bus.req_cmd_yumi_o), 64'(oh(exp_id)));
        sb_q.push_back(exp_id);
        @(posedge clk); #1;
        bus.io_cmd_yumi_i = 1'b0;
        bus.req_cmd_v_i   = 2'b00;
        #1;
        chk("cmd_gap", 64'(bus.io_cmd_v_o), 64'd0);
    endtask

    task automatic respond(input int stall);
        int         id;
        logic       has;
        logic [1:0] m;
        logic [MW-1:0] d;
        has = (sb_q.size() != 0);
        id  = has ? sb_q[0] : 0;
        d   = $urandom;
        bus.io_resp_i        = d;
        bus.io_resp_v_i      = 1'b1;
        bus.req_resp_ready_i = 2'b11;
        if (has && stall > 0) begin
            m = 2'b11;
            m[id[0]] = 1'b0;
            bus.req_resp_ready_i = m;
            for (int c = 0; c < stall; c++) begin
                #1;
                chk("stall_ready", 64'(bus.io_resp_ready_o), 64'd0);
                chk("stall_v", 64'(bus.req_resp_v_o), 64'(oh(id)));
                @(posedge clk); #1;
            end
            bus.req_resp_ready_i = 2'b11;
        end
        #1;
        chk("resp_v", 64'(bus.req_resp_v_o), has ? 64'(oh(id)) : 64'd0);
        chk("resp_ready", 64'(bus.io_resp_ready_o), 64'd1);
        chk("resp_data", 64'(bus.req_resp_o), 64'(d));
        if (has) void'(sb_q.pop_front());
        @(posedge clk); #1;
        bus.io_resp_v_i = 1'b0;
    endtask

    task automatic hold_no_grant(input logic [1:0] vmask, input int cycles, input string nm);
        bus.req_cmd_v_i = vmask;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            chk(nm, 64'(bus.io_cmd_v_o), 64'd0);
        end
        bus.req_cmd_v_i = 2'b00;
    endtask

    initial begin
        tbl[0] = '{2'b11, 0};
        tbl[1] = '{2'b11, 1};
        tbl[2] = '{2'b01, 0};
        tbl[3] = '{2'b01, 0};
        tbl[4] = '{2'b10, 1};
        tbl[5] = '{2'b11, 0};
        tbl[6] = '{2'b10, 1};

        drain                = 1'b0;
        bus.req_cmd_i        = '0;
        bus.io_cmd_yumi_i    = 1'b1;
        bus.req_cmd_v_i      = 2'b11;
        bus.io_resp_i        = '0;
        bus.io_resp_v_i      = 1'b1;
        bus.req_resp_ready_i = 2'b11;
        rst                  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_v", 64'(bus.io_cmd_v_o), 64'd0);
        chk("rst_yumi", 64'(bus.req_cmd_yumi_o), 64'd0);
        chk("rst_resp_v", 64'(bus.req_resp_v_o), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_err", 64'(err), 64'd0);
        bus.io_cmd_yumi_i = 1'b0;
        bus.req_cmd_v_i   = 2'b00;
        bus.io_resp_v_i   = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Round-robin grant table, then in-order response routing.
        for (int i = 0; i < 7; i++) issue(tbl[i].v, tbl[i].exp_id);
        chk("busy_idle", 64'(idle), 64'd0);
        for (int i = 0; i < 7; i++) respond((i == 0) ? 2 : 0);
        chk("tbl_idle", 64'(idle), 64'd1);

        // Requester 1 then 0; response to 1 stalls until its ready rises.
        issue(2'b10, 1);
        issue(2'b01, 0);
        respond(3);
        respond(0);

        // Credit exhaustion at max_credits_p outstanding.
        for (int i = 0; i < MC; i++) issue(2'b01, 0);
        hold_no_grant(2'b01, 6, "full_block");
        respond(0);
        issue(2'b01, 0);
        respond(0);

        // Response accepted in the same cycle as a new yumi at 7 credits.
        bus.req_cmd_v_i = 2'b10;
        wait_cmd_v();
        bus.io_cmd_yumi_i    = 1'b1;
        bus.io_resp_v_i      = 1'b1;
        bus.req_resp_ready_i = 2'b11;
        #1;
        chk("same_yumi", 64'(bus.req_cmd_yumi_o), 64'(2'b10));
        chk("same_resp_v", 64'(bus.req_resp_v_o), 64'(oh(sb_q[0])));
        void'(sb_q.pop_front());
        sb_q.push_back(1);
        @(posedge clk); #1;
        bus.io_cmd_yumi_i = 1'b0;
        bus.io_resp_v_i   = 1'b0;
        bus.req_cmd_v_i   = 2'b00;
        issue(2'b10, 1);
        hold_no_grant(2'b11, 5, "same_full_block");
        for (int i = 0; i < MC; i++) respond(0);
        chk("same_idle", 64'(idle), 64'd1);

        // Drain raised while a command is held in SEND with 3 outstanding.
        issue(2'b11, 0);
        issue(2'b11, 1);
        issue(2'b11, 0);
        bus.req_cmd_v_i = 2'b11;
        wait_cmd_v();
        drain = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk("drain_hold", 64'(bus.io_cmd_v_o), 64'd1);
        end
        bus.io_cmd_yumi_i = 1'b1;
        #1;
        chk("drain_yumi", 64'(bus.req_cmd_yumi_o), 64'(2'b10));
        sb_q.push_back(1);
        @(posedge clk); #1;
        bus.io_cmd_yumi_i = 1'b0;
        hold_no_grant(2'b11, 5, "drain_block");
        for (int i = 0; i < 3; i++) respond(0);
        chk("drain_not_idle", 64'(idle), 64'd0);
        respond(0);
        chk("drain_idle", 64'(idle), 64'd1);
        drain = 1'b0;
        issue(2'b11, 0);
        respond(0);

        // Stray response with nothing outstanding.
        bus.io_resp_v_i = 1'b1;
        #1;
        chk("stray_ready", 64'(bus.io_resp_ready_o), 64'd1);
        chk("stray_v", 64'(bus.req_resp_v_o), 64'd0);
        chk("stray_err_pre", 64'(err), 64'd0);
        @(posedge clk); #1;
        bus.io_resp_v_i = 1'b0;
        chk("stray_err", 64'(err), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("stray_err_sticky", 64'(err), 64'd1);

        // Reset asserted mid-SEND with credits outstanding.
        issue(2'b11, 1);
        issue(2'b11, 0);
        bus.req_cmd_v_i = 2'b11;
        wait_cmd_v();
        bus.io_cmd_yumi_i = 1'b1;
        bus.io_resp_v_i   = 1'b1;
        rst = 1'b1;
        #1;
        chk("mid_rst_cmd_v", 64'(bus.io_cmd_v_o), 64'd0);
        chk("mid_rst_yumi", 64'(bus.req_cmd_yumi_o), 64'd0);
        chk("mid_rst_resp_v", 64'(bus.req_resp_v_o), 64'd0);
        chk("mid_rst_idle", 64'(idle), 64'd1);
        chk("mid_rst_err", 64'(err), 64'd0);
        bus.io_cmd_yumi_i = 1'b0;
        bus.io_resp_v_i   = 1'b0;
        bus.req_cmd_v_i   = 2'b00;
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        bus.io_resp_v_i = 1'b1;
        @(posedge clk); #1;
        bus.io_resp_v_i = 1'b0;
        chk("post_rst_err", 64'(err), 64'd1);
        issue(2'b11, 0);
        respond(0);
        chk("final_idle", 64'(idle), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bp_me_cfg_cmd_arbiter.md
BP_ME_CFG_CMD_ARBITER -- requirements
Module: bp_me_cfg_cmd_arbiter

Interface
REQ-001 SHALL have parameter num_req_p, default 2, number of command requesters (2..8).
REQ-002 SHALL have parameter msg_width_p, default 128, width of one packed memory message (header plus data).
REQ-003 SHALL have parameter max_credits_p, default 8, maximum outstanding commands on the IO channel (power of 2, >=2).
REQ-004 SHALL have port clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_i  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_cmd_i  in  num_req_p*msg_width_p  command from requester r at slice r.
REQ-007 SHALL have port req_cmd_v_i  in  num_req_p  per-requester command valid.
REQ-008 SHALL have port req_cmd_yumi_o  out  num_req_p  per-requester command consumed; one-hot or zero.
REQ-009 SHALL have port io_cmd_o  out  msg_width_p  command to IO network.
REQ-010 SHALL have port io_cmd_v_o  out  1  command valid to IO network.
REQ-011 SHALL have port io_cmd_yumi_i  in  1  IO network consumed io_cmd_o.
REQ-012 SHALL have port io_resp_i  in  msg_width_p  response from IO network.
REQ-013 SHALL have port io_resp_v_i  in  1  response valid.
REQ-014 SHALL have port io_resp_ready_o  out  1  arbiter can accept response.
REQ-015 SHALL have port req_resp_o  out  msg_width_p  response broadcast to all requesters (equals io_resp_i).
REQ-016 SHALL have port req_resp_v_o  out  num_req_p  per-requester response valid; one-hot or zero.
REQ-017 SHALL have port req_resp_ready_i  in  num_req_p  per-requester response ready.
REQ-018 SHALL have port drain_i  in  1  stop granting new commands.
REQ-019 SHALL have port idle_o  out  1  no grant held and zero credits outstanding.
REQ-020 SHALL have port err_o  out  1  sticky: response received with no outstanding command.

Function
REQ-021 SHALL implement FSM states IDLE, SEND, DRAIN.
REQ-022 IDLE: if ~drain_i, credits not full and any req_cmd_v_i, SHALL grant the round-robin winner (search starts at last_grant+1, wrapping) and go to SEND; if drain_i, SHALL go to DRAIN.
REQ-023 SEND: io_cmd_v_o=1, io_cmd_o=req_cmd_i slice of the granted requester; grant SHALL stay fixed until io_cmd_yumi_i.
REQ-024 On io_cmd_yumi_i: req_cmd_yumi_o[grant]=1 combinationally that cycle; last_grant<=grant; push grant ID into ID FIFO; next state IDLE (grant evaluation restarts next cycle, so max 1 command per 2 cycles).
REQ-025 Requesters SHALL hold req_cmd_v_i and data stable until yumi; arbiter need not handle withdrawal.
REQ-026 Credit counter, width clog2(max_credits_p+1): +1 on io_cmd_yumi_i, -1 on accepted response (io_resp_v_i & io_resp_ready_o); both same cycle: unchanged.
REQ-027 Credits full (count==max_credits_p) SHALL block grant in IDLE; a grant already in SEND never occurs at full since grant requires not-full.
REQ-028 ID FIFO depth max_credits_p, in-order; push and pop same cycle legal, including at full.
REQ-029 When FIFO nonempty: req_resp_v_o[head]=io_resp_v_i, io_resp_ready_o=req_resp_ready_i[head]; pop on accept.
REQ-030 When FIFO empty: io_resp_ready_o=1, req_resp_v_o=0, response dropped, err_o<=1 if io_resp_v_i.
REQ-031 DRAIN: no grants; when credits==0 and ~drain_i, SHALL return to IDLE; drain_i in SEND SHALL NOT abort the held command.
REQ-032 idle_o=1 iff state!=SEND and credits==0.

Reset
REQ-033 On reset_i assertion, asynchronously: state IDLE, last_grant=num_req_p-1 (requester 0 wins first), credits 0, FIFO empty, err_o 0.
REQ-034 During reset: io_cmd_v_o=0, req_cmd_yumi_o=0, req_resp_v_o=0, idle_o=1.
REQ-035 Reset mid-SEND or with credits outstanding SHALL discard all state; later stray responses raise err_o.

Verification
REQ-036 Both requesters valid continuously, yumi every SEND cycle -> grants alternate 0,1,0,1; one command per 2 cycles.
REQ-037 max_credits_p=8, no responses, requester 0 streams -> exactly 8 io_cmd yumis, then io_cmd_v_o stays 0; one response -> 9th command issued.
REQ-038 Issue cmd from r1 then r0, return 2 responses -> req_resp_v_o=2'b10 then 2'b01; with req_resp_ready_i[1]=0, io_resp_ready_o=0 until raised.
REQ-039 Response accepted in same cycle as a new yumi at 7 credits -> credits stay 7, FIFO head/tail correct.
REQ-040 drain_i raised while in SEND with 3 outstanding -> held command completes, no new grant, idle_o=1 after 4th response.
REQ-041 io_resp_v_i with no outstanding commands -> io_resp_ready_o=1, req_resp_v_o=0, err_o=1 until reset.
